// File: rtl/ptw_pkg.sv
// Shared definitions for the two-level page-table walker: PTE bit positions,
// walker state encoding and PTE classification helpers.
package ptw_pkg;

    localparam int unsigned PTE_V = 0;
    localparam int unsigned PTE_R = 1;
    localparam int unsigned PTE_W = 2;
    localparam int unsigned PTE_X = 3;

    typedef enum logic [2:0] {
        StIdle,
        StL1Req,
        StL1Wait,
        StL0Req,
        StL0Wait,
        StDone
    } ptw_state_e;

    // Helpers take only the four flag bits of a PTE.
    function automatic logic pte_is_leaf(input logic [3:0] flags);
        return flags[PTE_R] | flags[PTE_W] | flags[PTE_X];
    endfunction

    function automatic logic pte_is_fault(input logic [3:0] flags);
        return ~flags[PTE_V] | (flags[PTE_W] & ~flags[PTE_R]);
    endfunction

endpackage

// File: rtl/ptw_pte_decode.sv
// Combinational PTE decoder: classifies a PTE and extracts the next-level
// table base and the {X,W,R} permission bits.
module ptw_pte_decode
    import ptw_pkg::*;
(
    input  logic [31:0] pte_i,
    output logic        leaf_o,
    output logic        fault_o,
    output logic [31:0] next_base_o,
    output logic [2:0]  perm_o
);

    // Bits [9:4] are reserved/software bits with no meaning to the walker.
    logic [5:0] unused_rsw;
    assign unused_rsw = pte_i[9:4];

    assign leaf_o      = pte_is_leaf(pte_i[3:0]);
    assign fault_o     = pte_is_fault(pte_i[3:0]);
    assign next_base_o = {pte_i[31:10], 10'b0};
    assign perm_o      = {pte_i[PTE_X], pte_i[PTE_W], pte_i[PTE_R]};

endmodule

// File: rtl/page_table_walker.sv
// Two-level hardware page-table walker: turns one TLB-miss virtual address into
// one or two PTE reads and returns the physical address, permissions and fault.
module page_table_walker
    import ptw_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] ROOT_BASE = 32'h0000_0400
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              walk_req_valid_i,
    output logic              walk_req_ready_o,
    input  logic [ADDR_W-1:0] walk_vaddr_i,
    output logic              walk_resp_valid_o,
    input  logic              walk_resp_ready_i,
    output logic [ADDR_W-1:0] walk_paddr_o,
    output logic [2:0]        walk_perm_o,
    output logic              walk_super_o,
    output logic              walk_fault_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_resp_valid_i,
    output logic              mem_resp_ready_o,
    input  logic [31:0]       mem_data_i
);

    ptw_state_e        state_q, state_d;
    logic [ADDR_W-1:0] vaddr_q, vaddr_d;
    logic [31:0]       pte_q, pte_d;
    logic              super_q, super_d;
    // Holds walk_req_ready_o low until the first clock after reset release.
    logic              live_q;

    logic        dec_leaf;
    logic        dec_fault;
    logic [31:0] dec_next_base;
    logic [2:0]  dec_perm;
    logic        done_fault;

    ptw_pte_decode u_pte_decode (
        .pte_i       (pte_q),
        .leaf_o      (dec_leaf),
        .fault_o     (dec_fault),
        .next_base_o (dec_next_base),
        .perm_o      (dec_perm)
    );

    // A level-1 pointer never reaches DONE, so a non-leaf in DONE is a level-0 fault.
    assign done_fault = dec_fault | ~dec_leaf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            live_q  <= 1'b0;
            vaddr_q <= '0;
            pte_q   <= '0;
            super_q <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
            vaddr_q <= vaddr_d;
            pte_q   <= pte_d;
            super_q <= super_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        vaddr_d           = vaddr_q;
        pte_d             = pte_q;
        super_d           = super_q;
        walk_req_ready_o  = 1'b0;
        walk_resp_valid_o = 1'b0;
        walk_paddr_o      = '0;
        walk_perm_o       = '0;
        walk_super_o      = 1'b0;
        walk_fault_o      = 1'b0;
        mem_req_valid_o   = 1'b0;
        mem_addr_o        = '0;
        mem_resp_ready_o  = 1'b0;

        unique case (state_q)
            StIdle: begin
                walk_req_ready_o = live_q;
                if (walk_req_valid_i && live_q) begin
                    vaddr_d = walk_vaddr_i;
                    state_d = StL1Req;
                end
            end
            StL1Req: begin
                mem_req_valid_o = 1'b1;
                mem_addr_o      = ROOT_BASE + ADDR_W'({vaddr_q[31:22], 2'b00});
                if (mem_req_ready_i) state_d = StL1Wait;
            end
            StL1Wait: begin
                mem_resp_ready_o = 1'b1;
                if (mem_resp_valid_i) begin
                    pte_d = mem_data_i;
                    if (!pte_is_fault(mem_data_i[3:0]) && !pte_is_leaf(mem_data_i[3:0])) begin
                        super_d = 1'b0;
                        state_d = StL0Req;
                    end else begin
                        super_d = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StL0Req: begin
                mem_req_valid_o = 1'b1;
                mem_addr_o      = dec_next_base + ADDR_W'({vaddr_q[21:12], 2'b00});
                if (mem_req_ready_i) state_d = StL0Wait;
            end
            StL0Wait: begin
                mem_resp_ready_o = 1'b1;
                if (mem_resp_valid_i) begin
                    pte_d   = mem_data_i;
                    super_d = 1'b0;
                    state_d = StDone;
                end
            end
            StDone: begin
                walk_resp_valid_o = 1'b1;
                walk_fault_o      = done_fault;
                if (!done_fault) begin
                    walk_perm_o  = dec_perm;
                    walk_super_o = super_q;
                    walk_paddr_o = super_q ? {pte_q[31:22], vaddr_q[21:0]}
                                           : {pte_q[31:12], vaddr_q[11:0]};
                end
                if (walk_resp_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_page_table_walker.sv
// Self-checking bench for page_table_walker: directed table vectors, hand-written
// corner sequences and randomized walks checked against a behavioural model.
module tb_page_table_walker;

    localparam logic [31:0] ROOT = 32'h0000_0400;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        walk_req_valid = 1'b0;
    logic        walk_req_ready;
    logic [31:0] walk_vaddr = '0;
    logic        walk_resp_valid;
    logic        walk_resp_ready = 1'b0;
    logic [31:0] walk_paddr;
    logic [2:0]  walk_perm;
    logic        walk_super;
    logic        walk_fault;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_resp_valid;
    logic        mem_resp_ready;
    logic [31:0] mem_data;

    always #5 clk = ~clk;

    page_table_walker #(.ADDR_W(32), .ROOT_BASE(ROOT)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .walk_req_valid_i  (walk_req_valid),
        .walk_req_ready_o  (walk_req_ready),
        .walk_vaddr_i      (walk_vaddr),
        .walk_resp_valid_o (walk_resp_valid),
        .walk_resp_ready_i (walk_resp_ready),
        .walk_paddr_o      (walk_paddr),
        .walk_perm_o       (walk_perm),
        .walk_super_o      (walk_super),
        .walk_fault_o      (walk_fault),
        .mem_req_valid_o   (mem_req_valid),
        .mem_req_ready_i   (mem_req_ready),
        .mem_addr_o        (mem_addr),
        .mem_resp_valid_i  (mem_resp_valid),
        .mem_resp_ready_o  (mem_resp_ready),
        .mem_data_i        (mem_data)
    );

    int n_checks = 0;
    int n_pass = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_log [$];
    int mem_lat = 0;
    bit rand_lat = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    function automatic int pick_lat();
        if (rand_lat) return $urandom_range(0, mem_lat);
        return mem_lat;
    endfunction

    // Reference model: walks the page table in the associative memory directly.
    function automatic bit pte_bad(input logic [31:0] p);
        return (p % 2 == 0) || (((p >> 2) & 1) == 1 && ((p >> 1) & 1) == 0);
    endfunction

    function automatic bit pte_leaf(input logic [31:0] p);
        return ((p >> 1) & 7) != 0;
    endfunction

    task automatic ref_walk(input logic [31:0] va, output logic [31:0] pa,
                            output logic [2:0] perm, output logic sup, output logic flt,
                            output int nrd, output logic [31:0] a0, output logic [31:0] a1);
        logic [31:0] p1, p0;
        pa = 0; perm = 0; sup = 0; flt = 0; a1 = 0;
        a0 = ROOT + (va >> 22) * 4;
        p1 = mem_rd(a0);
        nrd = 1;
        if (pte_bad(p1)) flt = 1;
        else if (pte_leaf(p1)) begin
            sup  = 1;
            pa   = (p1 & 32'hFFC0_0000) | (va & 32'h003F_FFFF);
            perm = 3'((p1 >> 1) & 7);
        end else begin
            a1  = (p1 & 32'hFFFF_FC00) + ((va >> 12) & 32'h3FF) * 4;
            p0  = mem_rd(a1);
            nrd = 2;
            if (pte_bad(p0) || !pte_leaf(p0)) flt = 1;
            else begin
                pa   = (p0 & 32'hFFFF_F000) | (va & 32'h0000_0FFF);
                perm = 3'((p0 >> 1) & 7);
            end
        end
    endtask

    // Memory responder, driven on negedges; handshakes complete on the next posedge.
    initial begin : responder
        int rs;
        int dly;
        logic [31:0] addr;
        rs = 0; dly = 0; addr = 0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rs = 0;
                mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_data = '0;
            end else begin
                if (rs == 4) begin
                    mem_resp_valid = 1'b0; mem_data = '0; rs = 0;
                end
                if (rs == 3) begin
                    dly--;
                    if (dly <= 0) begin
                        mem_resp_valid = 1'b1; mem_data = mem_rd(addr); rs = 4;
                    end
                end
                if (rs == 2) begin
                    rd_log.push_back(addr);
                    mem_req_ready = 1'b0;
                    dly = pick_lat();
                    if (dly == 0) begin
                        mem_resp_valid = 1'b1; mem_data = mem_rd(addr); rs = 4;
                    end else rs = 3;
                end
                if (rs == 1) begin
                    dly--;
                    if (dly <= 0) begin mem_req_ready = 1'b1; rs = 2; end
                end
                if (rs == 0 && mem_req_valid) begin
                    addr = mem_addr;
                    dly = pick_lat();
                    if (dly == 0) begin mem_req_ready = 1'b1; rs = 2; end
                    else rs = 1;
                end
            end
        end
    end

    task automatic run_walk(input logic [31:0] va, input int hold, output logic [31:0] pa,
                            output logic [2:0] perm, output logic sup, output logic flt,
                            output int lat, output bit timeout);
        int n;
        timeout = 1'b0; pa = 0; perm = 0; sup = 0; flt = 0; lat = 0;
        rd_log.delete();
        @(negedge clk);
        walk_req_valid = 1'b1;
        walk_vaddr = va;
        n = 0;
        while (!walk_req_ready && n < 50) begin @(negedge clk); n++; end
        if (!walk_req_ready) begin
            walk_req_valid = 1'b0; timeout = 1'b1; return;
        end
        @(posedge clk); #1;
        walk_req_valid = 1'b0;
        walk_vaddr = '0;
        while (!walk_resp_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        if (!walk_resp_valid) begin timeout = 1'b1; return; end
        pa = walk_paddr; perm = walk_perm; sup = walk_super; flt = walk_fault;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(walk_resp_valid), 32'd1);
            check("hold_paddr", walk_paddr, pa);
            check("hold_perm", 32'(walk_perm), 32'(perm));
            check("hold_fault", 32'(walk_fault), 32'(flt));
        end
        walk_resp_ready = 1'b1;
        @(posedge clk); #1;
        walk_resp_ready = 1'b0;
        check("resp_dropped", 32'(walk_resp_valid), 32'd0);
    endtask

    typedef struct {
        logic [31:0] va;
        logic [31:0] pa;
        logic [2:0]  perm;
        logic        sup;
        logic        flt;
        int          nrd;
        logic [31:0] rd0;
        logic [31:0] rd1;
        int          hold;
    } vec_t;

    vec_t vecs [6];

    initial begin : main
        logic [31:0] pa, e_pa, e_a0, e_a1;
        logic [2:0]  perm, e_perm;
        logic        sup, flt, e_sup, e_flt;
        int          lat, e_nrd, n;
        bit          tmo;

        mem[32'h400] = 32'h0000_0801;
        mem[32'h404] = 32'h1234_0007;
        mem[32'h800] = 32'h1000_000F;
        mem[32'h804] = 32'h1100_000F;
        mem[32'h808] = 32'h1200_0007;

        vecs[0] = '{32'h0000_0000, 32'h1000_0000, 3'b111, 1'b0, 1'b0, 2, 32'h400, 32'h800, 0};
        vecs[1] = '{32'h0000_1ABC, 32'h1100_0ABC, 3'b111, 1'b0, 1'b0, 2, 32'h400, 32'h804, 0};
        vecs[2] = '{32'h0000_2010, 32'h1200_0010, 3'b011, 1'b0, 1'b0, 2, 32'h400, 32'h808, 5};
        vecs[3] = '{32'h0040_0123, 32'h1200_0123, 3'b011, 1'b1, 1'b0, 1, 32'h404, 32'h0, 0};
        vecs[4] = '{32'h0000_3000, 32'h0000_0000, 3'b000, 1'b0, 1'b1, 2, 32'h400, 32'h80C, 0};
        vecs[5] = '{32'h0080_0000, 32'h0000_0000, 3'b000, 1'b0, 1'b1, 1, 32'h408, 32'h0, 0};

        // Reset state
        #1;
        check("rst_req_ready", 32'(walk_req_ready), 32'd0);
        check("rst_resp_valid", 32'(walk_resp_valid), 32'd0);
        check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_mem_resp_ready", 32'(mem_resp_ready), 32'd0);
        check("rst_paddr", walk_paddr, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("ready_before_first_clk", 32'(walk_req_ready), 32'd0);
        @(posedge clk); #1;
        check("ready_after_first_clk", 32'(walk_req_ready), 32'd1);

        // Directed vectors with single-cycle memory; latency counted in posedges after accept
        // (valid in the 5th / 3rd cycle counting the accept cycle).
        mem_lat = 0; rand_lat = 1'b0;
        for (int i = 0; i < 6; i++) begin
            run_walk(vecs[i].va, vecs[i].hold, pa, perm, sup, flt, lat, tmo);
            check($sformatf("vec%0d_timeout", i), 32'(tmo), 32'd0);
            check($sformatf("vec%0d_paddr", i), pa, vecs[i].pa);
            check($sformatf("vec%0d_perm", i), 32'(perm), 32'(vecs[i].perm));
            check($sformatf("vec%0d_super", i), 32'(sup), 32'(vecs[i].sup));
            check($sformatf("vec%0d_fault", i), 32'(flt), 32'(vecs[i].flt));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(2 * vecs[i].nrd));
            check($sformatf("vec%0d_nreads", i), 32'(rd_log.size()), 32'(vecs[i].nrd));
            if (rd_log.size() > 0) check($sformatf("vec%0d_rd0", i), rd_log[0], vecs[i].rd0);
            if (vecs[i].nrd == 2 && rd_log.size() > 1)
                check($sformatf("vec%0d_rd1", i), rd_log[1], vecs[i].rd1);
        end

        // Extra memory wait cycles lengthen the walk one-for-one.
        mem_lat = 2;
        run_walk(32'h0000_0000, 0, pa, perm, sup, flt, lat, tmo);
        check("slow_mem_latency", 32'(lat), 32'd12);
        check("slow_mem_paddr", pa, 32'h1000_0000);
        mem_lat = 0;

        // New request offered in the same cycle DONE completes.
        @(negedge clk);
        walk_req_valid = 1'b1; walk_vaddr = 32'h0;
        n = 0;
        while (!walk_req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        walk_req_valid = 1'b0;
        n = 0;
        while (!walk_resp_valid && n < 50) begin @(posedge clk); #1; n++; end
        check("b2b_first_done", 32'(walk_resp_valid), 32'd1);
        walk_resp_ready = 1'b1; walk_req_valid = 1'b1; walk_vaddr = 32'h0040_0123;
        check("b2b_busy_in_done", 32'(walk_req_ready), 32'd0);
        @(posedge clk); #1;
        walk_resp_ready = 1'b0;
        check("b2b_idle_ready", 32'(walk_req_ready), 32'd1);
        check("b2b_resp_cleared", 32'(walk_resp_valid), 32'd0);
        @(posedge clk); #1;
        walk_req_valid = 1'b0;
        check("b2b_accepted", 32'(walk_req_ready), 32'd0);
        n = 0;
        while (!walk_resp_valid && n < 50) begin @(posedge clk); #1; n++; end
        check("b2b_second_paddr", walk_paddr, 32'h1200_0123);
        check("b2b_second_super", 32'(walk_super), 32'd1);
        walk_resp_ready = 1'b1;
        @(posedge clk); #1;
        walk_resp_ready = 1'b0;

        // Reset while waiting for the level-0 PTE.
        mem_lat = 3;
        rd_log.delete();
        @(negedge clk);
        walk_req_valid = 1'b1; walk_vaddr = 32'h0;
        n = 0;
        while (!walk_req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        walk_req_valid = 1'b0;
        n = 0;
        while (!(rd_log.size() == 2 && mem_resp_ready) && n < 60) begin
            @(negedge clk); #1; n++;
        end
        check("midwalk_in_l0_wait", 32'(mem_resp_ready), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_req_ready", 32'(walk_req_ready), 32'd0);
        check("midrst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("midrst_mem_resp_ready", 32'(mem_resp_ready), 32'd0);
        check("midrst_resp_valid", 32'(walk_resp_valid), 32'd0);
        check("midrst_mem_addr", mem_addr, 32'd0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        #1 check("midrst_ready_held_low", 32'(walk_req_ready), 32'd0);
        @(posedge clk); #1;
        check("midrst_ready_back", 32'(walk_req_ready), 32'd1);
        mem_lat = 0;
        run_walk(32'h0000_0000, 0, pa, perm, sup, flt, lat, tmo);
        check("post_rst_timeout", 32'(tmo), 32'd0);
        check("post_rst_paddr", pa, 32'h1000_0000);
        check("post_rst_perm", 32'(perm), 32'd7);

        // Randomized page tables and walks against the reference model.
        mem.delete();
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                logic [31:0] base;
                base = 32'h0002_0000 + i * 32'h400;
                mem[ROOT + i * 4] = base | 32'h1;
                for (int j = 0; j < 8; j++)
                    if ($urandom_range(0, 5) != 0)
                        mem[base + j * 4] = ($urandom & 32'hFFFF_FC00) | $urandom_range(0, 15);
            end else begin
                mem[ROOT + i * 4] = ($urandom & 32'hFFFF_FC00) | $urandom_range(0, 15);
            end
        end
        mem_lat = 2; rand_lat = 1'b1;
        for (int k = 0; k < 40; k++) begin
            logic [31:0] va;
            va = ($urandom_range(0, 8) << 22) | ($urandom_range(0, 8) << 12) | ($urandom & 32'hFFF);
            ref_walk(va, e_pa, e_perm, e_sup, e_flt, e_nrd, e_a0, e_a1);
            run_walk(va, $urandom_range(0, 2), pa, perm, sup, flt, lat, tmo);
            check($sformatf("rnd%0d_timeout", k), 32'(tmo), 32'd0);
            check($sformatf("rnd%0d_paddr va=%08h", k, va), pa, e_pa);
            check($sformatf("rnd%0d_perm", k), 32'(perm), 32'(e_perm));
            check($sformatf("rnd%0d_super", k), 32'(sup), 32'(e_sup));
            check($sformatf("rnd%0d_fault", k), 32'(flt), 32'(e_flt));
            check($sformatf("rnd%0d_nreads", k), 32'(rd_log.size()), 32'(e_nrd));
            if (rd_log.size() > 0) check($sformatf("rnd%0d_rd0", k), rd_log[0], e_a0);
            if (e_nrd == 2 && rd_log.size() > 1) check($sformatf("rnd%0d_rd1", k), rd_log[1], e_a1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
